// File: rtl/dpll_pkg.sv
// dpll_pkg: shared constants for the DPLL ID-counter / post-divider slice.
//   DIV_N_DEFAULT : default post-divider ratio (even, >= 2)
//   LOCK_MULT     : lock threshold is LOCK_MULT * DIV_N correction-free pulses
//   div_width()   : divider count width for a given ratio
package dpll_pkg;

  localparam int unsigned DIV_N_DEFAULT = 8;
  localparam int unsigned LOCK_MULT     = 4;

  function automatic int unsigned div_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dpll_div.sv
// dpll_div: modulo-DIV_N post-divider driven by the ID-counter pulse stream.
// Ports:
//   clk     in  : reference clock, rising edge
//   rst     in  : synchronous active-high reset
//   idout   in  : registered ID-counter pulse; each high cycle advances phase
//   phase   out : current divider count, 0 .. DIV_N-1
//   clk_out out : recovered clock, high while phase >= DIV_N/2
module dpll_div
  import dpll_pkg::*;
#(
  parameter int unsigned DIV_N = DIV_N_DEFAULT,
  parameter int unsigned CNT_W = div_width(DIV_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idout,
  output logic [CNT_W-1:0] phase,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_N - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV_N / 2);

  logic [CNT_W-1:0] phase_nxt;

  always_comb begin
    phase_nxt = phase;
    if (idout) begin
      phase_nxt = (phase == LAST) ? '0 : phase + CNT_W'(1);
    end
  end

  // clk_out is derived from the next phase so both update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      clk_out <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      clk_out <= (phase_nxt >= HALF);
    end
  end

endmodule

// File: rtl/dpll_idc.sv
// dpll_idc: increment/decrement counter plus post-divider for the DPLL.
// Loop-filter add/sub pulses insert or delete one ID-counter pulse; the
// pulse stream (nominally one per two clocks) is divided by DIV_N.
// Ports:
//   clk     in  : N x f0 reference clock, rising edge
//   rst     in  : synchronous active-high reset
//   add     in  : one-cycle phase-advance request
//   sub     in  : one-cycle phase-retard request
//   idout   out : registered ID-counter pulse stream
//   clk_out out : registered recovered clock, f_clk / (2*DIV_N)
//   phase   out : current divider count
//   drop    out : one-cycle pulse when a request is discarded
//   lock    out : lock indicator
// Build option: define DPLL_IDC_LOCK_EN to enable the lock counter;
// otherwise lock is tied low.
module dpll_idc
  import dpll_pkg::*;
#(
  parameter int unsigned DIV_N = DIV_N_DEFAULT,
  parameter int unsigned CNT_W = div_width(DIV_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add,
  input  logic             sub,
  output logic             idout,
  output logic             clk_out,
  output logic [CNT_W-1:0] phase,
  output logic             drop,
  output logic             lock
);

  logic t;
  logic add_p, sub_p;
  logic add_use, sub_use;
  logic add_nxt, sub_nxt, drop_nxt, idout_nxt;

  // add_p may only be spent on a t==0 slot (extra pulse), sub_p only on a
  // t==1 slot (suppressed pulse).
  assign add_use   = ~t & add_p;
  assign sub_use   =  t & sub_p;
  assign idout_nxt = (t & ~sub_p) | (~t & add_p);

  // Capture works on the flags as they stand after this cycle's consumption,
  // so a request arriving as its flag is spent re-arms it instead of dropping.
  always_comb begin
    add_nxt  = add_p & ~add_use;
    sub_nxt  = sub_p & ~sub_use;
    drop_nxt = 1'b0;
    if (add && !sub) begin
      if (sub_nxt)      sub_nxt  = 1'b0;
      else if (add_nxt) drop_nxt = 1'b1;
      else              add_nxt  = 1'b1;
    end else if (sub && !add) begin
      if (add_nxt)      add_nxt  = 1'b0;
      else if (sub_nxt) drop_nxt = 1'b1;
      else              sub_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t     <= 1'b0;
      add_p <= 1'b0;
      sub_p <= 1'b0;
      idout <= 1'b0;
      drop  <= 1'b0;
    end else begin
      t     <= ~t;
      add_p <= add_nxt;
      sub_p <= sub_nxt;
      idout <= idout_nxt;
      drop  <= drop_nxt;
    end
  end

  dpll_div #(
    .DIV_N (DIV_N),
    .CNT_W (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .idout   (idout),
    .phase   (phase),
    .clk_out (clk_out)
  );

`ifdef DPLL_IDC_LOCK_EN
  localparam int unsigned LOCK_THR = LOCK_MULT * DIV_N;
  localparam int unsigned LCNT_W   = $clog2(LOCK_THR + 1);

  logic [LCNT_W-1:0] lock_cnt, lock_cnt_nxt;

  // Saturating count of correction-free pulses; applied corrections and
  // discarded requests both restart it.
  always_comb begin
    lock_cnt_nxt = lock_cnt;
    if (add_use || sub_use || drop_nxt) begin
      lock_cnt_nxt = '0;
    end else if (idout_nxt && (lock_cnt != LCNT_W'(LOCK_THR))) begin
      lock_cnt_nxt = lock_cnt + LCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_nxt;
      lock     <= (lock_cnt_nxt == LCNT_W'(LOCK_THR));
    end
  end
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_dpll_idc.sv
// tb_dpll_idc: directed bench for dpll_idc with DIV_N = 8.
// Stimulus pushes hand-computed expectations (clk_out edge cycles, drop
// cycles, per-cycle probes of idout/phase/lock) into queues; a negedge
// monitor pops and compares them as the DUT produces them.
// Cycle numbering: cyc = n after the n-th rising edge following reset release.
module tb_dpll_idc;

  localparam int unsigned DIV_N = 8;
  localparam int unsigned CNT_W = 3;
`ifdef DPLL_IDC_LOCK_EN
  localparam int LOCK_ON = 1;
`else
  localparam int LOCK_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             add = 1'b0;
  logic             sub = 1'b0;
  logic             idout, clk_out, drop, lock;
  logic [CNT_W-1:0] phase;

  dpll_idc #(
    .DIV_N (DIV_N),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .add     (add),
    .sub     (sub),
    .idout   (idout),
    .clk_out (clk_out),
    .phase   (phase),
    .drop    (drop),
    .lock    (lock)
  );

  always #5 clk = ~clk;

  int   cyc   = 0;
  logic rst_q = 1'b0;

  always @(posedge clk) begin
    rst_q <= rst;
    cyc   <= rst ? 0 : cyc + 1;
  end

  typedef struct { int cyc; logic lvl; } edge_exp_t;
  typedef enum { P_IDOUT, P_PHASE, P_LOCK } psig_t;
  typedef struct { int cyc; psig_t sig; int val; } probe_t;

  edge_exp_t edge_q[$];
  int        drop_q[$];
  probe_t    probe_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_edge(input int c, input logic l);
    edge_exp_t e;
    e.cyc = c;
    e.lvl = l;
    edge_q.push_back(e);
  endfunction

  function automatic void push_probe(input int c, input psig_t s, input int v);
    probe_t p;
    p.cyc = c;
    p.sig = s;
    p.val = v;
    probe_q.push_back(p);
  endfunction

  // Monitor
  logic prev_clk = 1'b0;

  always @(negedge clk) begin
    if (rst_q) begin
      check("rst_idout", idout, 0);
      check("rst_clk_out", clk_out, 0);
      check("rst_phase", phase, 0);
      check("rst_drop", drop, 0);
      check("rst_lock", lock, 0);
      prev_clk = clk_out;
    end else begin
      if (clk_out !== prev_clk) begin
        if (edge_q.size() == 0) begin
          check("clk_out_unexpected_edge_cyc", cyc, -1);
        end else begin
          edge_exp_t e;
          e = edge_q.pop_front();
          check("clk_out_edge_cyc", cyc, e.cyc);
          check("clk_out_edge_lvl", clk_out, e.lvl);
        end
        prev_clk = clk_out;
      end
      if (drop) begin
        if (drop_q.size() == 0) check("drop_unexpected_cyc", cyc, -1);
        else                    check("drop_cyc", cyc, drop_q.pop_front());
      end
      while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
        probe_t p;
        p = probe_q.pop_front();
        if (p.cyc < cyc) check("probe_missed_cyc", cyc, p.cyc);
        else begin
          case (p.sig)
            P_IDOUT: check("probe_idout", idout, p.val);
            P_PHASE: check("probe_phase", phase, p.val);
            default: check("probe_lock", lock, p.val);
          endcase
        end
      end
    end
  end

  // Stimulus
  task automatic wait_cyc(input int k);
    for (int i = 0; i < 2000 && cyc != k; i++) @(negedge clk);
    if (cyc != k) check("wait_timeout_cyc", cyc, k);
  endtask

  // Request sampled at rising edge k.
  task automatic pulse(input int k, input logic a, input logic s);
    wait_cyc(k - 1);
    add = a;
    sub = s;
    @(negedge clk);
    add = 1'b0;
    sub = 1'b0;
  endtask

  initial begin
    // Segment 1: idle, single add, single sub, cancelling pairs,
    // three back-to-back adds, then reset with add_p pending.
    push_edge(9, 1);   push_edge(17, 0);  push_edge(25, 1);  push_edge(33, 0);
    push_edge(39, 1);  push_edge(47, 0);  push_edge(55, 1);  push_edge(63, 0);
    push_edge(73, 1);  push_edge(81, 0);  push_edge(89, 1);  push_edge(97, 0);
    push_edge(105, 1); push_edge(113, 0); push_edge(121, 1); push_edge(129, 0);
    push_edge(134, 1); push_edge(141, 0); push_edge(149, 1);
    drop_q.push_back(132);
    push_probe(1, P_IDOUT, 0);
    push_probe(2, P_IDOUT, 1);
    push_probe(9, P_PHASE, 4);
    push_probe(37, P_IDOUT, 1);
    push_probe(38, P_PHASE, 3);
    push_probe(68, P_IDOUT, 0);
    push_probe(69, P_PHASE, 2);
    push_probe(100, P_LOCK, 0);
    push_probe(131, P_IDOUT, 1);
    push_probe(133, P_PHASE, 3);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    pulse(36, 1'b1, 1'b0);
    pulse(66, 1'b0, 1'b1);
    pulse(100, 1'b1, 1'b1);
    pulse(108, 1'b0, 1'b1);
    pulse(109, 1'b1, 1'b0);
    pulse(130, 1'b1, 1'b0);
    pulse(131, 1'b1, 1'b0);
    pulse(132, 1'b1, 1'b0);
    pulse(152, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Segment 2: fresh start after reset, lock behaviour, one add.
    push_edge(9, 1);   push_edge(17, 0);  push_edge(25, 1);  push_edge(33, 0);
    push_edge(41, 1);  push_edge(49, 0);  push_edge(57, 1);  push_edge(65, 0);
    push_edge(72, 1);  push_edge(79, 0);  push_edge(87, 1);  push_edge(95, 0);
    push_edge(103, 1);
    push_probe(1, P_IDOUT, 0);
    push_probe(2, P_IDOUT, 1);
    push_probe(63, P_LOCK, 0);
    push_probe(64, P_LOCK, LOCK_ON);
    push_probe(70, P_LOCK, LOCK_ON);
    push_probe(71, P_IDOUT, 1);
    push_probe(71, P_LOCK, 0);
    push_probe(72, P_PHASE, 4);

    @(negedge clk);
    rst = 1'b0;

    pulse(70, 1'b1, 1'b0);
    wait_cyc(110);

    check("edge_q_leftover", edge_q.size(), 0);
    check("drop_q_leftover", drop_q.size(), 0);
    check("probe_q_leftover", probe_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
